// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

    localparam int INSTR_BYTES  = 4;
    localparam int ENTRY_ADDR_W = 64;
    localparam int ENTRY_INST_W = 32;

    typedef struct packed {
        logic [ENTRY_INST_W-1:0] inst;
        logic [ENTRY_ADDR_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [63:0] sext19(input logic [18:0] v);
        return {{45{v[18]}}, v};
    endfunction

    function automatic logic [63:0] sext26(input logic [25:0] v);
        return {{38{v[25]}}, v};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {instruction, pc} entries with synchronous flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           push_ok;
    logic           pop_ok;

    assign valid   = (count != '0);
    assign push_ok = push && (count != (PW+1)'(DEPTH));
    assign pop_ok  = pop && valid;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: nothing is visible until count marks it valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit_pipelined.sv
// Fetch front end: owns the PC, issues credit-limited reads to a 1-cycle instruction
// memory and queues returned instructions for decode; branch redirects flush and re-steer.
module fetch_unit_pipelined
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              BrTaken,
    input  logic              UncondBr,
    input  logic [18:0]       CondAddr19,
    input  logic [25:0]       BrAddr26,
    input  logic [ADDR_W-1:0] br_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] redirect_pc
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic [CW-1:0]     count;
    logic [CW:0]       occupied;
    logic [63:0]       offset;
    logic              issue;
    logic              push;
    logic              pop;
    logic              head_valid;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    always_comb begin
        offset = UncondBr ? (sext26(BrAddr26) << 2) : (sext19(CondAddr19) << 2);
    end

    assign redirect_pc = br_pc + offset[ADDR_W-1:0];

    // A request is only issued when the FIFO is guaranteed room for its return.
    assign occupied = {1'b0, count} + (CW+1)'(inflight);
    assign issue    = !reset && !BrTaken && (occupied < (CW+1)'(QDEPTH));

    assign imem_req  = issue;
    assign imem_addr = pc;

    assign push = inflight && !BrTaken;
    assign pop  = head_valid && inst_ready && !BrTaken;

    assign push_entry.inst = ENTRY_INST_W'(imem_rdata);
    assign push_entry.pc   = ENTRY_ADDR_W'(req_pc);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (BrTaken) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc     <= pc + ADDR_W'(INSTR_BYTES);
                req_pc <= pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (BrTaken),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .valid     (head_valid),
        .count     (count)
    );

    assign inst_valid = head_valid;
    assign inst       = head_valid ? INST_W'(head.inst) : '0;
    assign inst_pc    = head_valid ? ADDR_W'(head.pc) : '0;

endmodule

// File: tb/tb_fetch_unit_pipelined.sv
// Scoreboard bench for fetch_unit_pipelined: directed stimulus, expected stream queued, monitor compares.
module tb_fetch_unit_pipelined;

    localparam int          ADDR_W = 64;
    localparam int          INST_W = 32;
    localparam int          QDEPTH = 4;
    localparam logic [63:0] RST_PC = 64'h100;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        BrTaken = 1'b0;
    logic        UncondBr = 1'b0;
    logic [18:0] CondAddr19 = '0;
    logic [25:0] BrAddr26 = '0;
    logic [63:0] br_pc = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [63:0] redirect_pc;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    fetch_unit_pipelined #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .QDEPTH   (QDEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .BrTaken     (BrTaken),
        .UncondBr    (UncondBr),
        .CondAddr19  (CondAddr19),
        .BrAddr26    (BrAddr26),
        .br_pc       (br_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .redirect_pc (redirect_pc)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    // Instruction memory model: one-cycle read, garbage when not requested.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic br, input logic unc,
                                 input logic [18:0] c19, input logic [25:0] b26,
                                 input logic [63:0] bpc, input logic rdy);
        @(posedge clk);
        #1;
        reset      = rst;
        BrTaken    = br;
        UncondBr   = unc;
        CondAddr19 = c19;
        BrAddr26   = b26;
        br_pc      = bpc;
        inst_ready = rdy;
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectStream(input logic [63:0] start, input int n);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            e.pc   = start + 64'(4 * i);
            e.inst = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every accepted head must match the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && !BrTaken && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL sb_empty actual_pc=%h required=none", inst_pc);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_inst", 64'(inst), 64'(e.inst));
                checkOutput("sb_pc", inst_pc, e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          req_cnt;
        logic [63:0] stall_pc;

        // Reset state
        applyStimulus(1, 0, 0, '0, '0, '0, 1);
        applyStimulus(1, 0, 0, '0, '0, '0, 1);
        @(negedge clk);
        checkOutput("rst_req", 64'(imem_req), 64'd0);
        checkOutput("rst_valid", 64'(inst_valid), 64'd0);
        checkOutput("rst_inst", 64'(inst), 64'd0);
        checkOutput("rst_inst_pc", inst_pc, 64'd0);

        // Sequential fetch from RESET_PC
        applyStimulus(0, 0, 0, '0, '0, '0, 1);
        expectStream(RST_PC, 64);
        @(negedge clk);
        checkOutput("t1_addr0", imem_addr, 64'h100);
        checkOutput("t1_req0", 64'(imem_req), 64'd1);
        hold(1);
        @(negedge clk);
        checkOutput("t1_addr1", imem_addr, 64'h104);
        hold(1);
        @(negedge clk);
        checkOutput("t1_addr2", imem_addr, 64'h108);
        checkOutput("t1_valid", 64'(inst_valid), 64'd1);
        checkOutput("t1_inst_pc", inst_pc, 64'h100);

        // Stall: credit limit caps outstanding work at QDEPTH
        applyStimulus(1, 0, 0, '0, '0, '0, 0);
        expectStream(RST_PC, 64);
        applyStimulus(0, 0, 0, '0, '0, '0, 0);
        req_cnt  = 0;
        stall_pc = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req) req_cnt++;
            if (i == 5) stall_pc = inst_pc;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("t2_req_count", 64'(req_cnt), 64'd4);
        checkOutput("t2_req_idle", 64'(imem_req), 64'd0);
        checkOutput("t2_valid", 64'(inst_valid), 64'd1);
        checkOutput("t2_head_pc", inst_pc, 64'h100);
        checkOutput("t2_head_stable", stall_pc, 64'h100);

        // Drain while refilling: one instruction per cycle, order kept by scoreboard
        applyStimulus(0, 0, 0, '0, '0, '0, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("t3_valid", 64'(inst_valid), 64'd1);
            @(posedge clk);
            #1;
        end

        // Conditional redirect backwards
        applyStimulus(0, 1, 0, 19'h7FFFE, '0, 64'h200, 1);
        expectStream(64'h1F8, 64);
        @(negedge clk);
        checkOutput("t4_target", redirect_pc, 64'h1F8);
        checkOutput("t4_no_issue", 64'(imem_req), 64'd0);
        applyStimulus(0, 0, 0, '0, '0, '0, 1);
        @(negedge clk);
        checkOutput("t4_addr", imem_addr, 64'h1F8);
        checkOutput("t4_flushed", 64'(inst_valid), 64'd0);
        hold(1);
        @(negedge clk);
        checkOutput("t4_flushed2", 64'(inst_valid), 64'd0);
        hold(1);
        @(negedge clk);
        checkOutput("t4_valid", 64'(inst_valid), 64'd1);
        checkOutput("t4_inst_pc", inst_pc, 64'h1F8);
        hold(4);

        // Back-to-back redirects; the unconditional one wraps to zero
        applyStimulus(0, 1, 0, 19'h00010, '0, 64'h1000, 1);
        exp_q.delete();
        @(negedge clk);
        checkOutput("t5_target_a", redirect_pc, 64'h1040);
        applyStimulus(0, 1, 1, '0, 26'h1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        expectStream(64'h0, 64);
        @(negedge clk);
        checkOutput("t5_target_b", redirect_pc, 64'h0);
        applyStimulus(0, 0, 0, '0, '0, '0, 1);
        @(negedge clk);
        checkOutput("t5_addr", imem_addr, 64'h0);
        checkOutput("t5_req", 64'(imem_req), 64'd1);
        hold(6);

        // Reset overrides a simultaneous redirect and drops returning data
        applyStimulus(0, 0, 0, '0, '0, '0, 0);
        hold(2);
        applyStimulus(1, 1, 0, 19'h5, '0, 64'h3000, 1);
        expectStream(RST_PC, 64);
        @(negedge clk);
        checkOutput("t6_req_in_reset", 64'(imem_req), 64'd0);
        applyStimulus(0, 0, 0, '0, '0, '0, 1);
        @(negedge clk);
        checkOutput("t6_addr", imem_addr, RST_PC);
        checkOutput("t6_empty", 64'(inst_valid), 64'd0);
        hold(1);
        @(negedge clk);
        checkOutput("t6_dropped", 64'(inst_valid), 64'd0);
        hold(1);
        @(negedge clk);
        checkOutput("t6_valid", 64'(inst_valid), 64'd1);
        checkOutput("t6_inst_pc", inst_pc, RST_PC);
        hold(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
